// File: rtl/reservation_station.sv
// Reservation station: holds dispatched integer ops until both operands resolve, snoops ALU/LSB
// broadcasts, issues the lowest-index ready entry to the ALU. Optional macro: RS_WAKEUP_BYPASS_EN.
module reservation_station #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    output logic                 full,
    input  logic                 issue,
    input  logic [6:0]           iss_opcode,
    input  logic [2:0]           iss_funct3,
    input  logic                 iss_funct7,
    input  logic [31:0]          iss_rs1_val,
    input  logic                 iss_rs1_dep,
    input  logic [ROB_POS_W-1:0] iss_rs1_tag,
    input  logic [31:0]          iss_rs2_val,
    input  logic                 iss_rs2_dep,
    input  logic [ROB_POS_W-1:0] iss_rs2_tag,
    input  logic [31:0]          iss_imm,
    input  logic [31:0]          iss_pc,
    input  logic [ROB_POS_W-1:0] iss_rob_pos,
    input  logic                 alu_res,
    input  logic [ROB_POS_W-1:0] alu_res_rob_pos,
    input  logic [31:0]          alu_res_val,
    input  logic                 lsb_res,
    input  logic [ROB_POS_W-1:0] lsb_res_rob_pos,
    input  logic [31:0]          lsb_res_val,
    output logic                 alu_en,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_funct3,
    output logic                 alu_funct7,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(RS_SIZE);

    typedef struct packed {
        logic                 busy;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [DATA_W-1:0]    v1;
        logic                 q1_dep;
        logic [ROB_POS_W-1:0] q1_tag;
        logic [DATA_W-1:0]    v2;
        logic                 q2_dep;
        logic [ROB_POS_W-1:0] q2_tag;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } entry_t;

    entry_t            ent   [RS_SIZE];
    entry_t            ent_n [RS_SIZE];
    entry_t            new_ent;
    logic [RS_SIZE-1:0] q1_hit;
    logic [RS_SIZE-1:0] q2_hit;
    logic [DATA_W-1:0] q1_fwd [RS_SIZE];
    logic [DATA_W-1:0] q2_fwd [RS_SIZE];
    logic [RS_SIZE-1:0] ready;
    logic              sel_vld;
    logic [IDX_W-1:0]  sel_idx;
    logic              free_vld;
    logic [IDX_W-1:0]  free_idx;
    logic              full_n;
    logic [DATA_W-1:0] sel_val1;
    logic [DATA_W-1:0] sel_val2;

    // Broadcast snoop per entry; the ALU broadcast wins when both match
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            q1_hit[i] = 1'b0;
            q1_fwd[i] = '0;
            q2_hit[i] = 1'b0;
            q2_fwd[i] = '0;
            if (ent[i].busy && ent[i].q1_dep) begin
                if (alu_res && alu_res_rob_pos == ent[i].q1_tag) begin
                    q1_hit[i] = 1'b1;
                    q1_fwd[i] = alu_res_val;
                end else if (lsb_res && lsb_res_rob_pos == ent[i].q1_tag) begin
                    q1_hit[i] = 1'b1;
                    q1_fwd[i] = lsb_res_val;
                end
            end
            if (ent[i].busy && ent[i].q2_dep) begin
                if (alu_res && alu_res_rob_pos == ent[i].q2_tag) begin
                    q2_hit[i] = 1'b1;
                    q2_fwd[i] = alu_res_val;
                end else if (lsb_res && lsb_res_rob_pos == ent[i].q2_tag) begin
                    q2_hit[i] = 1'b1;
                    q2_fwd[i] = lsb_res_val;
                end
            end
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = ent[i].busy && (!ent[i].q1_dep || q1_hit[i]) && (!ent[i].q2_dep || q2_hit[i]);
`else
            ready[i] = ent[i].busy && !ent[i].q1_dep && !ent[i].q2_dep;
`endif
        end
    end

    // Lowest-index ready entry for select, lowest-index free entry for dispatch
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
            if (!ent[i].busy) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        sel_val1 = q1_hit[sel_idx] ? q1_fwd[sel_idx] : ent[sel_idx].v1;
        sel_val2 = q2_hit[sel_idx] ? q2_fwd[sel_idx] : ent[sel_idx].v2;
    end

    // New entry, with operands captured from a same-cycle broadcast
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.opcode  = iss_opcode;
        new_ent.funct3  = iss_funct3;
        new_ent.funct7  = iss_funct7;
        new_ent.v1      = iss_rs1_val;
        new_ent.q1_dep  = iss_rs1_dep;
        new_ent.q1_tag  = iss_rs1_tag;
        new_ent.v2      = iss_rs2_val;
        new_ent.q2_dep  = iss_rs2_dep;
        new_ent.q2_tag  = iss_rs2_tag;
        new_ent.imm     = iss_imm;
        new_ent.pc      = iss_pc;
        new_ent.rob_pos = iss_rob_pos;
        if (iss_rs1_dep) begin
            if (alu_res && alu_res_rob_pos == iss_rs1_tag) begin
                new_ent.v1     = alu_res_val;
                new_ent.q1_dep = 1'b0;
            end else if (lsb_res && lsb_res_rob_pos == iss_rs1_tag) begin
                new_ent.v1     = lsb_res_val;
                new_ent.q1_dep = 1'b0;
            end
        end
        if (iss_rs2_dep) begin
            if (alu_res && alu_res_rob_pos == iss_rs2_tag) begin
                new_ent.v2     = alu_res_val;
                new_ent.q2_dep = 1'b0;
            end else if (lsb_res && lsb_res_rob_pos == iss_rs2_tag) begin
                new_ent.v2     = lsb_res_val;
                new_ent.q2_dep = 1'b0;
            end
        end
    end

    // Next entry state: wakeup, free the selected entry, then dispatch into a slot free before this edge
    always_comb begin
        ent_n = ent;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (q1_hit[i]) begin
                ent_n[i].v1     = q1_fwd[i];
                ent_n[i].q1_dep = 1'b0;
            end
            if (q2_hit[i]) begin
                ent_n[i].v2     = q2_fwd[i];
                ent_n[i].q2_dep = 1'b0;
            end
        end
        if (sel_vld) begin
            ent_n[sel_idx].busy = 1'b0;
        end
        if (issue && !full && free_vld) begin
            ent_n[free_idx] = new_ent;
        end
        full_n = 1'b1;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            full_n = full_n & ent_n[i].busy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent[i] <= '0;
            end
            full        <= 1'b0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
`ifdef SIM
            if (issue && full) begin
                $display("reservation_station: issue while full dropped, rob_pos=%0d", iss_rob_pos);
            end
`endif
            ent    <= ent_n;
            full   <= full_n;
            alu_en <= sel_vld;
            if (sel_vld) begin
                alu_opcode  <= ent[sel_idx].opcode;
                alu_funct3  <= ent[sel_idx].funct3;
                alu_funct7  <= ent[sel_idx].funct7;
                alu_val1    <= sel_val1;
                alu_val2    <= sel_val2;
                alu_imm     <= ent[sel_idx].imm;
                alu_pc      <= ent[sel_idx].pc;
                alu_rob_pos <= ent[sel_idx].rob_pos;
            end
        end
    end
endmodule
